mmio_player_bank: RTL and testbench

MMIO_PLAYER_BANK -- requirements
Module: mmio_player_bank

---
 rtl/mmio_player_bank.sv | 163 ++++++++++++++++
 tb/tb_mmio_player_bank.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_player_bank.sv
// mmio_player_bank: memory-mapped bank of per-player shadow records with
// frame-synchronous commit to the display bus, plus debounced controller
// pads with sticky, read-to-clear press events.
module mmio_player_bank #(
    parameter int          NUM_PLAYERS     = 2,
    parameter int          PAD_BITS        = 16,
    parameter int          DEBOUNCE_CYCLES = 4,
    parameter logic [12:0] BASE_ADDR       = 13'h1000
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [12:0]                     address,
    input  logic [31:0]                     data_in,
    input  logic                            wren,
    output logic [31:0]                     data_out,
    output logic                            hit,
    input  logic [NUM_PLAYERS*PAD_BITS-1:0] gpio,
    input  logic                            vsync_pulse,
    output logic [NUM_PLAYERS*128-1:0]      vga_bus
);

    localparam int NB = NUM_PLAYERS * PAD_BITS;
    localparam int RB = NUM_PLAYERS * 128;
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    // Counter value at which one more differing cycle completes the debounce.
    localparam logic [CW-1:0] DC_LAST    = CW'(DEBOUNCE_CYCLES - 1);
    // Players plus the global block, eight words each.
    localparam logic [13:0]   SPAN       = 14'((NUM_PLAYERS + 1) * 8);
    localparam logic [10:0]   GLOBAL_IDX = 11'(NUM_PLAYERS);

    // State registers.
    logic [RB-1:0]         shadow_q, shadow_d;
    logic [RB-1:0]         vga_q, vga_d;
    logic                  pending_q, pending_d;
    logic [31:0]           frame_q, frame_d;
    logic [NB-1:0]         level_q, level_d;
    logic [NB-1:0][CW-1:0] cnt_q, cnt_d;
    logic [NB-1:0]         event_q, event_d;
    logic [31:0]           data_out_q, data_out_d;
    logic                  hit_q, hit_d;

    // Decode signals.
    logic [13:0] off_s;
    logic        in_bank_s;
    logic [10:0] idx_s;
    logic [2:0]  word_s;
    logic        is_global_s;
    logic        commit_fire_s;
    logic        commit_req_s;
    logic [NB-1:0] clr_s;

    // Split the address into block index and word within the block.
    always_comb begin
        off_s       = {1'b0, address} - {1'b0, BASE_ADDR};
        in_bank_s   = (address >= BASE_ADDR) && (off_s < SPAN);
        idx_s       = off_s[13:3];
        word_s      = off_s[2:0];
        is_global_s = in_bank_s && (idx_s == GLOBAL_IDX);
    end

    // Per-bit debounce: count consecutive disagreeing cycles, flip on the last.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        for (int b = 0; b < NB; b++) begin
            if (gpio[b] != level_q[b]) begin
                if (cnt_q[b] == DC_LAST) begin
                    level_d[b] = ~level_q[b];
                    cnt_d[b]   = {CW{1'b0}};
                end else begin
                    cnt_d[b] = cnt_q[b] + CW'(1);
                end
            end else begin
                cnt_d[b] = {CW{1'b0}};
            end
        end
    end

    // Sticky press events; a word-5 read clears, but a same-edge press survives.
    always_comb begin
        clr_s = {NB{1'b0}};
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            clr_s[p*PAD_BITS +: PAD_BITS] =
                {PAD_BITS{in_bank_s && (idx_s == 11'(p)) && (word_s == 3'd5)}};
        end
        event_d = (event_q & ~clr_s) | (level_d & ~level_q);
    end

    // Shadow writes, commit request and the vsync-aligned commit.
    always_comb begin
        commit_fire_s = vsync_pulse && pending_q;
        commit_req_s  = wren && is_global_s && (word_s == 3'd0) && data_in[0];
        shadow_d      = shadow_q;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            for (int w = 0; w < 4; w++) begin
                shadow_d[p*128 + w*32 +: 32] =
                    (wren && in_bank_s && (idx_s == 11'(p)) && (word_s == 3'(w)))
                    ? data_in : shadow_q[p*128 + w*32 +: 32];
            end
        end
        // The display copy takes the pre-write shadow so a same-edge write waits a frame.
        vga_d     = commit_fire_s ? shadow_q : vga_q;
        frame_d   = commit_fire_s ? (frame_q + 32'd1) : frame_q;
        pending_d = (pending_q && !commit_fire_s) || commit_req_s;
    end

    // Read mux; anything outside the bank reads as zero.
    always_comb begin
        logic [31:0] pw_v;
        logic [31:0] gw_v;
        data_out_d = 32'h0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            case (word_s)
                3'd0:    pw_v = shadow_q[p*128 +   0 +: 32];
                3'd1:    pw_v = shadow_q[p*128 +  32 +: 32];
                3'd2:    pw_v = shadow_q[p*128 +  64 +: 32];
                3'd3:    pw_v = shadow_q[p*128 +  96 +: 32];
                3'd4:    pw_v = 32'(level_q[p*PAD_BITS +: PAD_BITS]);
                3'd5:    pw_v = 32'(event_q[p*PAD_BITS +: PAD_BITS]);
                default: pw_v = 32'h0;
            endcase
            data_out_d = data_out_d |
                ((in_bank_s && (idx_s == 11'(p))) ? pw_v : 32'h0);
        end
        case (word_s)
            3'd0:    gw_v = {31'h0, pending_q};
            3'd1:    gw_v = frame_q;
            default: gw_v = 32'h0;
        endcase
        data_out_d = data_out_d | (is_global_s ? gw_v : 32'h0);
        hit_d      = in_bank_s;
    end

    // Register all state; synchronous reset overrides every other update.
    always_ff @(posedge clock) begin
        if (reset) begin
            shadow_q   <= {RB{1'b0}};
            vga_q      <= {RB{1'b0}};
            pending_q  <= 1'b0;
            frame_q    <= 32'h0;
            level_q    <= {NB{1'b0}};
            cnt_q      <= {(NB*CW){1'b0}};
            event_q    <= {NB{1'b0}};
            data_out_q <= 32'h0;
            hit_q      <= 1'b0;
        end else begin
            shadow_q   <= shadow_d;
            vga_q      <= vga_d;
            pending_q  <= pending_d;
            frame_q    <= frame_d;
            level_q    <= level_d;
            cnt_q      <= cnt_d;
            event_q    <= event_d;
            data_out_q <= data_out_d;
            hit_q      <= hit_d;
        end
    end

    assign data_out = data_out_q;
    assign hit      = hit_q;
    assign vga_bus  = vga_q;

endmodule

// File: tb/tb_mmio_player_bank.sv
// Directed testbench for mmio_player_bank with default parameters.
module tb_mmio_player_bank;

    localparam int          NP   = 2;
    localparam int          PB   = 16;
    localparam logic [12:0] BASE = 13'h1000;
    localparam logic [12:0] G    = 13'h1010;

    logic             clock = 1'b0;
    logic             reset;
    logic [12:0]      address;
    logic [31:0]      data_in;
    logic             wren;
    logic [31:0]      data_out;
    logic             hit;
    logic [NP*PB-1:0] gpio;
    logic             vsync_pulse;
    logic [NP*128-1:0] vga_bus;

    int total = 0;
    int bad   = 0;

    logic [31:0] d;
    logic        h;

    mmio_player_bank #(
        .NUM_PLAYERS(NP), .PAD_BITS(PB), .DEBOUNCE_CYCLES(4), .BASE_ADDR(BASE)
    ) dut (
        .clock(clock), .reset(reset), .address(address), .data_in(data_in),
        .wren(wren), .data_out(data_out), .hit(hit), .gpio(gpio),
        .vsync_pulse(vsync_pulse), .vga_bus(vga_bus)
    );

    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [12:0] a, input logic [31:0] v);
        address = a; data_in = v; wren = 1'b1;
        cyc();
        wren = 1'b0; address = 13'h0; data_in = 32'h0;
    endtask

    task automatic rd(input logic [12:0] a, output logic [31:0] v, output logic hh);
        address = a; wren = 1'b0;
        cyc();
        v = data_out; hh = hit;
        address = 13'h0;
    endtask

    task automatic pulse();
        vsync_pulse = 1'b1;
        cyc();
        vsync_pulse = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; address = BASE; data_in = 32'hFFFFFFFF; wren = 1'b1; vsync_pulse = 1'b1;
        cyc(); cyc();
        reset = 1'b0; wren = 1'b0; vsync_pulse = 1'b0; address = 13'h0; data_in = 32'h0;
        total++; if (data_out !== 32'h0) begin bad++; $display("FAIL reset_dout got=%h exp=%h", data_out, 32'h0); end
        total++; if (hit !== 1'b0) begin bad++; $display("FAIL reset_hit got=%b exp=0", hit); end
        total++; if (vga_bus !== {(NP*128){1'b0}}) begin bad++; $display("FAIL reset_vga got=%h exp=0", vga_bus); end
        rd(G, d, h);
        total++; if (d !== 32'h0 || h !== 1'b1) begin bad++; $display("FAIL reset_pending got=%h/%b exp=0/1", d, h); end
        rd(BASE, d, h);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_shadow got=%h exp=0", d); end
    endtask

    task automatic test_read_decode();
        wr(BASE + 13'd10, 32'h12345678);
        wr(BASE + 13'd6, 32'hFFFFFFFF);
        wr(BASE + 13'd4, 32'h0000FFFF);
        wr(G + 13'd1, 32'h00000005);
        rd(BASE + 13'd10, d, h);
        total++; if (d !== 32'h12345678 || h !== 1'b1) begin bad++; $display("FAIL p1w2_read got=%h/%b exp=12345678/1", d, h); end
        rd(13'h0000, d, h);
        total++; if (d !== 32'h0 || h !== 1'b0) begin bad++; $display("FAIL outside_low got=%h/%b exp=0/0", d, h); end
        rd(BASE + 13'd6, d, h);
        total++; if (d !== 32'h0 || h !== 1'b1) begin bad++; $display("FAIL word6_read got=%h/%b exp=0/1", d, h); end
        rd(BASE + 13'd4, d, h);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL ro_level_write got=%h exp=0", d); end
        rd(G + 13'd1, d, h);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL ro_frame_write got=%h exp=0", d); end
        rd(G + 13'd7, d, h);
        total++; if (d !== 32'h0 || h !== 1'b1) begin bad++; $display("FAIL g7_edge got=%h/%b exp=0/1", d, h); end
        rd(G + 13'd8, d, h);
        total++; if (h !== 1'b0) begin bad++; $display("FAIL past_top hit=%b exp=0", h); end
        rd(BASE - 13'd1, d, h);
        total++; if (h !== 1'b0) begin bad++; $display("FAIL below_base hit=%b exp=0", h); end
    endtask

    task automatic test_no_commit();
        wr(BASE, 32'hAAAA5555);
        pulse();
        total++; if (vga_bus !== {(NP*128){1'b0}}) begin bad++; $display("FAIL nocommit_vga got=%h exp=0", vga_bus); end
        rd(G + 13'd1, d, h);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL nocommit_frame got=%h exp=0", d); end
    endtask

    task automatic test_commit();
        wr(BASE + 13'd3, 32'hDEADBEEF);
        wr(G, 32'h00000001);
        rd(G, d, h);
        total++; if (d !== 32'h1) begin bad++; $display("FAIL pending_set got=%h exp=1", d); end
        total++; if (vga_bus !== {(NP*128){1'b0}}) begin bad++; $display("FAIL vga_before_pulse got=%h exp=0", vga_bus); end
        pulse();
        total++; if (vga_bus[127:96] !== 32'hDEADBEEF) begin bad++; $display("FAIL commit_w3 got=%h exp=deadbeef", vga_bus[127:96]); end
        total++; if (vga_bus[31:0] !== 32'hAAAA5555) begin bad++; $display("FAIL commit_w0 got=%h exp=aaaa5555", vga_bus[31:0]); end
        total++; if (vga_bus[128+64 +: 32] !== 32'h12345678) begin bad++; $display("FAIL commit_p1w2 got=%h exp=12345678", vga_bus[128+64 +: 32]); end
        rd(G + 13'd1, d, h);
        total++; if (d !== 32'h1) begin bad++; $display("FAIL frame_one got=%h exp=1", d); end
        rd(G, d, h);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL pending_clear got=%h exp=0", d); end
    endtask

    task automatic test_back_to_back();
        wr(G, 32'h00000001);
        address = BASE + 13'd3; data_in = 32'h11111111; wren = 1'b1; vsync_pulse = 1'b1;
        cyc();
        wren = 1'b0; vsync_pulse = 1'b0; address = 13'h0;
        total++; if (vga_bus[127:96] !== 32'hDEADBEEF) begin bad++; $display("FAIL samedge_write_vga got=%h exp=deadbeef", vga_bus[127:96]); end
        rd(BASE + 13'd3, d, h);
        total++; if (d !== 32'h11111111) begin bad++; $display("FAIL samedge_write_shadow got=%h exp=11111111", d); end
        wr(G, 32'h00000001);
        pulse();
        total++; if (vga_bus[127:96] !== 32'h11111111) begin bad++; $display("FAIL second_commit got=%h exp=11111111", vga_bus[127:96]); end
        rd(G + 13'd1, d, h);
        total++; if (d !== 32'h3) begin bad++; $display("FAIL frame_three got=%h exp=3", d); end
    endtask

    task automatic test_same_edge();
        wr(BASE + 13'd1, 32'hCAFEF00D);
        address = G; data_in = 32'h1; wren = 1'b1; vsync_pulse = 1'b1;
        cyc();
        wren = 1'b0; vsync_pulse = 1'b0; address = 13'h0; data_in = 32'h0;
        total++; if (vga_bus[63:32] !== 32'h0) begin bad++; $display("FAIL req_vsync_nocopy got=%h exp=0", vga_bus[63:32]); end
        rd(G + 13'd1, d, h);
        total++; if (d !== 32'h3) begin bad++; $display("FAIL req_vsync_frame got=%h exp=3", d); end
        rd(G, d, h);
        total++; if (d !== 32'h1) begin bad++; $display("FAIL req_vsync_pending got=%h exp=1", d); end
        for (int i = 0; i < 7; i++) cyc();
        pulse();
        total++; if (vga_bus[63:32] !== 32'hCAFEF00D) begin bad++; $display("FAIL late_copy got=%h exp=cafef00d", vga_bus[63:32]); end
        rd(G + 13'd1, d, h);
        total++; if (d !== 32'h4) begin bad++; $display("FAIL late_frame got=%h exp=4", d); end
    endtask

    task automatic test_debounce();
        gpio = '0;
        address = BASE + 13'd4;
        gpio[0] = 1'b1;
        cyc(); cyc(); cyc();
        gpio[0] = 1'b0;
        cyc(); cyc();
        total++; if (data_out !== 32'h0) begin bad++; $display("FAIL glitch_level got=%h exp=0", data_out); end
        gpio[0] = 1'b1;
        cyc(); cyc(); cyc(); cyc();
        total++; if (data_out !== 32'h0) begin bad++; $display("FAIL level_early got=%h exp=0", data_out); end
        cyc();
        total++; if (data_out !== 32'h1) begin bad++; $display("FAIL level_after4 got=%h exp=1", data_out); end
        rd(BASE + 13'd5, d, h);
        total++; if (d !== 32'h1) begin bad++; $display("FAIL event_first got=%h exp=1", d); end
        rd(BASE + 13'd5, d, h);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL event_cleared got=%h exp=0", d); end
        // Press on bit 1 lands at the same edge as a clearing read.
        gpio[1] = 1'b1;
        cyc(); cyc(); cyc();
        rd(BASE + 13'd5, d, h);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL press_during_clear got=%h exp=0", d); end
        rd(BASE + 13'd5, d, h);
        total++; if (d !== 32'h2) begin bad++; $display("FAIL press_survives got=%h exp=2", d); end
        // Player 1 pad lands in its own word.
        gpio[PB] = 1'b1;
        cyc(); cyc(); cyc(); cyc();
        rd(BASE + 13'd12, d, h);
        total++; if (d !== 32'h1) begin bad++; $display("FAIL p1_level got=%h exp=1", d); end
        rd(BASE + 13'd4, d, h);
        total++; if (d !== 32'h3) begin bad++; $display("FAIL p0_level got=%h exp=3", d); end
    endtask

    task automatic test_mid_reset();
        gpio[2] = 1'b1;
        cyc(); cyc(); cyc(); cyc();
        wr(G, 32'h00000001);
        gpio = '0;
        reset = 1'b1; address = BASE + 13'd2; data_in = 32'h55; wren = 1'b1; vsync_pulse = 1'b1;
        cyc();
        reset = 1'b0; wren = 1'b0; vsync_pulse = 1'b0; address = 13'h0; data_in = 32'h0;
        total++; if (vga_bus !== {(NP*128){1'b0}}) begin bad++; $display("FAIL midreset_vga got=%h exp=0", vga_bus); end
        total++; if (data_out !== 32'h0 || hit !== 1'b0) begin bad++; $display("FAIL midreset_out got=%h/%b exp=0/0", data_out, hit); end
        rd(BASE + 13'd5, d, h);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL midreset_event got=%h exp=0", d); end
        rd(BASE + 13'd4, d, h);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL midreset_level got=%h exp=0", d); end
        rd(BASE + 13'd2, d, h);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL midreset_shadow got=%h exp=0", d); end
        rd(G, d, h);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL midreset_pending got=%h exp=0", d); end
        rd(G + 13'd1, d, h);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL midreset_frame got=%h exp=0", d); end
        pulse();
        total++; if (vga_bus !== {(NP*128){1'b0}}) begin bad++; $display("FAIL midreset_pulse_vga got=%h exp=0", vga_bus); end
    endtask

    initial begin
        reset = 1'b1; address = 13'h0; data_in = 32'h0; wren = 1'b0;
        gpio = '0; vsync_pulse = 1'b0;
        test_reset();
        test_read_decode();
        test_no_commit();
        test_commit();
        test_back_to_back();
        test_same_edge();
        test_debounce();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
